// File: rtl/byte_serial_ram_pkg.sv
// Shared definitions for the byte-serial RAM front end: command opcodes and
// controller state encoding.
package byte_serial_ram_pkg;

  localparam logic [1:0] OP_NOP        = 2'b00;
  localparam logic [1:0] OP_WRITE      = 2'b01;
  localparam logic [1:0] OP_READ       = 2'b10;
  localparam logic [1:0] OP_BYTE_WRITE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_COLLECT,
    S_WR_COMMIT,
    S_RD_ACCESS,
    S_RD_LOAD,
    S_RD_STREAM
  } state_t;

endpackage

// File: rtl/ram_sync_bwe.sv
// Small synchronous RAM with per-byte write enables and 1-cycle read latency.
// Storage has no reset; this is the drop-in point for the hard DFFRAM macro.
module ram_sync_bwe #(
  parameter int  DEPTH      = 8,
  parameter int  WORD_BYTES = 4,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [WORD_BYTES-1:0]   we,
  input  logic [AW-1:0]           addr,
  input  logic [8*WORD_BYTES-1:0] di,
  output logic [8*WORD_BYTES-1:0] dout
);

  logic [8*WORD_BYTES-1:0] r_mem [DEPTH];

  // Byte-lane writes and registered read on every enabled cycle
  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        if (we[i]) r_mem[addr][8*i +: 8] <= di[8*i +: 8];
      end
      dout <= r_mem[addr];
    end
  end

endmodule

// File: rtl/byte_serial_ram_ctrl.sv
// Byte-serial command front end for a byte-enable RAM: word/byte writes and
// burst reads over an 8-bit data path, with address auto-increment and wrap.
module byte_serial_ram_ctrl
  import byte_serial_ram_pkg::*;
#(
  parameter int  DEPTH      = 8,
  parameter int  WORD_BYTES = 4,
  parameter int  LEN_W      = 4,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int LANE_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [LANE_W-1:0] cmd_lane,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [7:0]        dout,
  output logic              dout_valid,
  output logic              busy
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

  state_t                  r_state, w_state_nxt;
  logic [ADDR_W-1:0]       r_addr;
  logic [LEN_W-1:0]        r_words;
  logic [LANE_W-1:0]       r_bcnt;
  logic [WORD_W-1:0]       r_wbuf, r_sh;
  logic [WORD_BYTES-1:0]   r_we;
  logic [7:0]              r_dout;
  logic                    r_dout_valid;
  logic [WORD_W-1:0]       w_ram_rdata, w_wbuf_shift, w_sh_next;
  logic [WORD_BYTES-1:0]   w_lane_we, w_ram_we;
  logic                    w_ram_en, w_last_byte;

  assign w_last_byte  = (r_bcnt == LAST_LANE);
  assign w_wbuf_shift = (r_wbuf >> 8) | (WORD_W'(din) << (8 * (WORD_BYTES - 1)));
  assign w_sh_next    = r_sh >> 8;
  assign dout         = r_dout;
  assign dout_valid   = r_dout_valid;

  // One-hot byte enable for BYTE_WRITE from the command lane index
  always_comb begin
    w_lane_we = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      w_lane_we[i] = (cmd_lane == LANE_W'(i));
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode, handshake outputs and RAM port control
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    din_ready   = 1'b0;
    busy        = 1'b1;
    w_ram_en    = 1'b0;
    w_ram_we    = '0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          case (cmd_op)
            OP_WRITE:      w_state_nxt = S_WR_COLLECT;
            OP_READ:       w_state_nxt = S_RD_ACCESS;
            OP_BYTE_WRITE: w_state_nxt = S_WR_COMMIT;
            default:       w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_WR_COLLECT: begin
        din_ready = 1'b1;
        if (din_valid && w_last_byte) w_state_nxt = S_WR_COMMIT;
      end
      S_WR_COMMIT: begin
        w_ram_en    = 1'b1;
        w_ram_we    = r_we;
        w_state_nxt = (r_words != '0) ? S_WR_COLLECT : S_IDLE;
      end
      S_RD_ACCESS: begin
        w_ram_en    = 1'b1;
        w_state_nxt = S_RD_LOAD;
      end
      S_RD_LOAD:   w_state_nxt = S_RD_STREAM;
      S_RD_STREAM: begin
        if (w_last_byte) w_state_nxt = (r_words != '0) ? S_RD_ACCESS : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: command latch, byte collection, address/word counters, read shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_words      <= '0;
      r_bcnt       <= '0;
      r_wbuf       <= '0;
      r_sh         <= '0;
      r_we         <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_op != OP_NOP) begin
            r_addr <= cmd_addr;
            r_bcnt <= '0;
            case (cmd_op)
              OP_WRITE: begin
                r_words <= cmd_len;
                r_we    <= '1;
              end
              OP_READ: r_words <= cmd_len;
              default: begin
                // din replicated to every lane; only the selected lane is enabled
                r_words <= '0;
                r_we    <= w_lane_we;
                r_wbuf  <= {WORD_BYTES{din}};
              end
            endcase
          end
        end
        S_WR_COLLECT: begin
          if (din_valid) begin
            r_wbuf <= w_wbuf_shift;
            r_bcnt <= w_last_byte ? '0 : r_bcnt + LANE_W'(1);
          end
        end
        S_WR_COMMIT: begin
          r_addr <= r_addr + ADDR_W'(1);
          if (r_words != '0) r_words <= r_words - LEN_W'(1);
        end
        S_RD_LOAD: begin
          r_sh         <= w_ram_rdata;
          r_dout       <= w_ram_rdata[7:0];
          r_dout_valid <= 1'b1;
          r_bcnt       <= '0;
        end
        S_RD_STREAM: begin
          if (w_last_byte) begin
            r_dout_valid <= 1'b0;
            r_bcnt       <= '0;
            r_addr       <= r_addr + ADDR_W'(1);
            if (r_words != '0) r_words <= r_words - LEN_W'(1);
          end else begin
            r_sh   <= w_sh_next;
            r_dout <= w_sh_next[7:0];
            r_bcnt <= r_bcnt + LANE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  ram_sync_bwe #(
    .DEPTH      (DEPTH),
    .WORD_BYTES (WORD_BYTES)
  ) u_ram (
    .clk  (clk),
    .en   (w_ram_en),
    .we   (w_ram_we),
    .addr (r_addr),
    .di   (r_wbuf),
    .dout (w_ram_rdata)
  );

endmodule

// File: tb/tb_byte_serial_ram_ctrl.sv
// Directed, table-driven bench for byte_serial_ram_ctrl (DEPTH=8, 4-byte words).
module tb_byte_serial_ram_ctrl;
  import byte_serial_ram_pkg::*;

  localparam int DEPTH = 8;
  localparam int WB    = 4;
  localparam int LEN_W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_addr;
  logic [3:0] cmd_len;
  logic [1:0] cmd_lane;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       busy;

  int total = 0;
  int bad   = 0;

  byte_serial_ram_ctrl #(
    .DEPTH      (DEPTH),
    .WORD_BYTES (WB),
    .LEN_W      (LEN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_lane   (cmd_lane),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       op;
    logic [2:0]       addr;
    logic [3:0]       len;
    logic [1:0]       lane;
    logic [2:0][31:0] w;   // write data, BYTE_WRITE byte in w[0][7:0], or expected read words
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] a, input logic [3:0] l,
                              input logic [1:0] ln, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2);
    vec_t v;
    v.op = op; v.addr = a; v.len = l; v.lane = ln; v.w = {w2, w1, w0};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [2:0] a, input logic [3:0] l,
                       input logic [1:0] ln, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l; cmd_lane = ln; din = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [3:0] l, input logic [2:0][31:0] w);
    issue(OP_WRITE, a, l, 2'd0, 8'h00);
    chk("wr_accept", {cmd_ready, din_ready, busy}, 3'b011);
    for (int k = 0; k <= int'(l); k++) begin
      for (int b = 0; b < WB; b++) begin
        if (k == 0 && b == 2) begin
          din_valid = 1'b0; din = 8'hFF;
          @(negedge clk);
          chk("wr_stall_ready", din_ready, 1'b1);
        end
        din = w[k][8*b +: 8]; din_valid = 1'b1;
        @(negedge clk);
      end
      din_valid = 1'b0;
      chk("wr_commit_state", {busy, din_ready}, 2'b10);
      @(negedge clk);
    end
    chk("wr_done", {busy, cmd_ready}, 2'b01);
  endtask

  task automatic do_read(input logic [2:0] a, input logic [3:0] l, input logic [2:0][31:0] w);
    issue(OP_READ, a, l, 2'd0, 8'h00);
    chk("rd_accept", {busy, dout_valid, cmd_ready}, 3'b100);
    for (int k = 0; k <= int'(l); k++) begin
      for (int z = 0; z < ((k == 0) ? 1 : 2); z++) begin
        @(negedge clk);
        chk("rd_gap", {busy, dout_valid}, 2'b10);
      end
      for (int b = 0; b < WB; b++) begin
        @(negedge clk);
        chk("rd_valid", dout_valid, 1'b1);
        chk("rd_byte", dout, w[k][8*b +: 8]);
      end
    end
    @(negedge clk);
    chk("rd_end", {busy, dout_valid, cmd_ready}, 3'b001);
    chk("rd_hold", dout, w[l][31:24]);
  endtask

  task automatic do_bwrite(input logic [2:0] a, input logic [1:0] ln, input logic [7:0] d);
    issue(OP_BYTE_WRITE, a, 4'd0, ln, d);
    din = 8'h00;
    chk("bw_commit", {busy, din_ready, cmd_ready}, 3'b100);
    @(negedge clk);
    chk("bw_done", {busy, cmd_ready}, 2'b01);
  endtask

  initial begin
    vecs[0]  = mk(OP_WRITE,      3'd2, 4'd0, 2'd0, 32'h44332211, 32'h0, 32'h0);
    vecs[1]  = mk(OP_READ,       3'd2, 4'd0, 2'd0, 32'h44332211, 32'h0, 32'h0);
    vecs[2]  = mk(OP_BYTE_WRITE, 3'd2, 4'd0, 2'd1, 32'h000000AB, 32'h0, 32'h0);
    vecs[3]  = mk(OP_READ,       3'd2, 4'd0, 2'd0, 32'h4433AB11, 32'h0, 32'h0);
    vecs[4]  = mk(OP_WRITE,      3'd7, 4'd1, 2'd0, 32'hA0A1A2A3, 32'hB0B1B2B3, 32'h0);
    vecs[5]  = mk(OP_READ,       3'd0, 4'd0, 2'd0, 32'hB0B1B2B3, 32'h0, 32'h0);
    vecs[6]  = mk(OP_WRITE,      3'd6, 4'd0, 2'd0, 32'hC0C1C2C3, 32'h0, 32'h0);
    vecs[7]  = mk(OP_READ,       3'd6, 4'd2, 2'd0, 32'hC0C1C2C3, 32'hA0A1A2A3, 32'hB0B1B2B3);
    vecs[8]  = mk(OP_BYTE_WRITE, 3'd0, 4'd0, 2'd3, 32'h0000005A, 32'h0, 32'h0);
    vecs[9]  = mk(OP_BYTE_WRITE, 3'd7, 4'd0, 2'd0, 32'h000000EE, 32'h0, 32'h0);
    vecs[10] = mk(OP_NOP,        3'd1, 4'd0, 2'd0, 32'h0, 32'h0, 32'h0);
    vecs[11] = mk(OP_READ,       3'd7, 4'd1, 2'd0, 32'hA0A1A2EE, 32'h5AB1B2B3, 32'h0);

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_addr = '0; cmd_len = '0;
    cmd_lane = '0; din = '0; din_valid = 1'b0;
    #2;
    chk("reset_outputs", {cmd_ready, din_ready, dout_valid, busy, dout}, {4'b1000, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      case (vecs[i].op)
        OP_WRITE:      do_write(vecs[i].addr, vecs[i].len, vecs[i].w);
        OP_READ:       do_read(vecs[i].addr, vecs[i].len, vecs[i].w);
        OP_BYTE_WRITE: do_bwrite(vecs[i].addr, vecs[i].lane, vecs[i].w[0][7:0]);
        default: begin
          issue(OP_NOP, vecs[i].addr, vecs[i].len, vecs[i].lane, 8'h00);
          chk("nop_idle", {busy, cmd_ready, din_ready}, 3'b010);
        end
      endcase
    end

    // READ presented during WR_COLLECT must be dropped, the write still lands
    issue(OP_WRITE, 3'd3, 4'd0, 2'd0, 8'h00);
    cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr = 3'd3; cmd_len = 4'd0;
    for (int b = 0; b < WB; b++) begin
      din = 8'(b + 1); din_valid = 1'b1;
      chk("busy_cmd_ready", cmd_ready, 1'b0);
      @(negedge clk);
    end
    cmd_valid = 1'b0; din_valid = 1'b0;
    chk("ign_commit", {busy, cmd_ready}, 2'b10);
    @(negedge clk);
    chk("ign_no_read", {busy, dout_valid}, 2'b00);
    do_read(3'd3, 4'd0, {32'h0, 32'h0, 32'h04030201});

    // Reset after two bytes of a write: immediate reset outputs, old word intact
    issue(OP_WRITE, 3'd2, 4'd0, 2'd0, 8'h00);
    din = 8'hDE; din_valid = 1'b1;
    @(negedge clk);
    din = 8'hAD;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {cmd_ready, din_ready, dout_valid, busy, dout}, {4'b1000, 8'h00});
    din_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(3'd2, 4'd0, {32'h0, 32'h0, 32'h4433AB11});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
